// File: rtl/tag_phase_sweep_gen_if.sv
// Stream bus carrying the per-lane phase words from the sweep generator to a
// downstream dds_freq_tune.
//   m_tdata  : NCHAN lanes of PHASE_WIDTH bits; lane k = bits [k*PHASE_WIDTH +: PHASE_WIDTH]
//   m_tvalid : beat valid (source)
//   m_tready : downstream ready (sink)
//   m_tlast  : last sample of a symbol
//   m_eos    : last sample of a sweep (implies m_tlast)
interface tag_phase_sweep_gen_if #(
  parameter int PHASE_WIDTH = 24,
  parameter int NCHAN       = 2
);
  logic [NCHAN*PHASE_WIDTH-1:0] m_tdata;
  logic                         m_tvalid;
  logic                         m_tready;
  logic                         m_tlast;
  logic                         m_eos;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    output m_eos,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    input  m_eos,
    output m_tready
  );
endinterface

// File: rtl/tag_phase_sweep_gen.sv
// Multi-channel phase-sweep generator feeding the phase port of dds_freq_tune.
// Each symbol is a linear phase ramp of nsig samples; the ramp increment moves
// by dph_inc per symbol and the symbol start phase drops by nph_shift. A sweep
// is nsymb symbols and a sync is nloc sweeps. Beats advance only on handshake.
// Ports:
//   clk, reset        clock, synchronous active-high reset (state + config defaults)
//   srst              soft restart: back to IDLE, counters cleared, config kept
//   cfg_load, cfg_*   configuration, latched only while IDLE
//   enable            level run request
//   m                 stream master (phase lanes, valid/ready, tlast, eos)
//   sync_ready        sticky: nloc sweeps completed
//   done              one-shot run complete
//   symb_count        current symbol (1-based)
//   loc_count         completed sweeps (saturating at nloc)
module tag_phase_sweep_gen #(
  parameter int PHASE_WIDTH = 24,
  parameter int NSIG_WIDTH  = 24,
  parameter int NSYMB_WIDTH = 16,
  parameter int NLOC_WIDTH  = 8,
  parameter int NCHAN       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         srst,
  input  logic                         cfg_load,
  input  logic [NSIG_WIDTH-1:0]        cfg_nsig,
  input  logic [NSYMB_WIDTH-1:0]       cfg_nsymb,
  input  logic [NLOC_WIDTH-1:0]        cfg_nloc,
  input  logic [PHASE_WIDTH-1:0]       cfg_start_ph,
  input  logic [PHASE_WIDTH-1:0]       cfg_start_inc,
  input  logic signed [PHASE_WIDTH-1:0] cfg_dph_inc,
  input  logic [PHASE_WIDTH-1:0]       cfg_nph_shift,
  input  logic [NCHAN*PHASE_WIDTH-1:0] cfg_chan_offset,
  input  logic                         cfg_oneshot,
  input  logic                         enable,
  tag_phase_sweep_gen_if.master        m,
  output logic                         sync_ready,
  output logic                         done,
  output logic [NSYMB_WIDTH-1:0]       symb_count,
  output logic [NLOC_WIDTH-1:0]        loc_count
);

  localparam logic [NSIG_WIDTH-1:0]         DEF_NSIG      = NSIG_WIDTH'(262144);
  localparam logic [NSYMB_WIDTH-1:0]        DEF_NSYMB     = NSYMB_WIDTH'(64);
  localparam logic [NLOC_WIDTH-1:0]         DEF_NLOC      = NLOC_WIDTH'(7);
  localparam logic [PHASE_WIDTH-1:0]        DEF_START_INC = PHASE_WIDTH'(4194304);
  localparam logic signed [PHASE_WIDTH-1:0] DEF_DPH_INC   = PHASE_WIDTH'(-32'sd131072);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Saturating sweep counter increment; stops at the configured limit.
  function automatic logic [NLOC_WIDTH-1:0] sat_inc_loc(
    input logic [NLOC_WIDTH-1:0] v,
    input logic [NLOC_WIDTH-1:0] lim
  );
    return (v >= lim) ? v : v + NLOC_WIDTH'(1);
  endfunction

  state_t                         state_q, state_d;
  logic [NSIG_WIDTH-1:0]          nsig_q, nsig_d;
  logic [NSYMB_WIDTH-1:0]         nsymb_q, nsymb_d;
  logic [NLOC_WIDTH-1:0]          nloc_q, nloc_d;
  logic [PHASE_WIDTH-1:0]         start_ph_q, start_ph_d;
  logic [PHASE_WIDTH-1:0]         start_inc_q, start_inc_d;
  logic signed [PHASE_WIDTH-1:0]  dph_inc_q, dph_inc_d;
  logic [PHASE_WIDTH-1:0]         nph_shift_q, nph_shift_d;
  logic [NCHAN*PHASE_WIDTH-1:0]   chan_off_q, chan_off_d;
  logic                           oneshot_q, oneshot_d;

  logic [NSIG_WIDTH-1:0]          n_q, n_d;
  logic [NSYMB_WIDTH-1:0]         symb_q, symb_d;
  logic [NLOC_WIDTH-1:0]          loc_q, loc_d;
  logic [PHASE_WIDTH-1:0]         phase_q, phase_d;
  logic [PHASE_WIDTH-1:0]         inc_q, inc_d;
  logic [PHASE_WIDTH-1:0]         sph_q, sph_d;
  logic                           sync_q, sync_d;

  logic [NSIG_WIDTH-1:0]          nsig_eff;
  logic [NSYMB_WIDTH-1:0]         nsymb_eff;
  logic [NLOC_WIDTH-1:0]          nloc_eff;
  logic                           running;
  logic                           last_sample;
  logic                           last_symb;
  logic                           hs;

  // Zero-length counts behave as one.
  assign nsig_eff  = (nsig_q  == '0) ? NSIG_WIDTH'(1)  : nsig_q;
  assign nsymb_eff = (nsymb_q == '0) ? NSYMB_WIDTH'(1) : nsymb_q;
  assign nloc_eff  = (nloc_q  == '0) ? NLOC_WIDTH'(1)  : nloc_q;

  assign running = (state_q == S_RUN);
  // >= rather than == so a shorter config loaded while paused mid-symbol
  // still terminates the symbol instead of running to counter wrap.
  assign last_sample = (n_q >= nsig_eff);
  assign last_symb   = (symb_q >= nsymb_eff);
  assign hs          = running && m.m_tready;

  assign m.m_tvalid = running;
  assign m.m_tlast  = running && last_sample;
  assign m.m_eos    = running && last_sample && last_symb;
  assign sync_ready = sync_q;
  assign done       = (state_q == S_DONE);
  assign symb_count = symb_q;
  assign loc_count  = loc_q;

  always_comb begin
    m.m_tdata = '0;
    for (int k = 0; k < NCHAN; k++) begin
      m.m_tdata[k*PHASE_WIDTH +: PHASE_WIDTH] = phase_q + chan_off_q[k*PHASE_WIDTH +: PHASE_WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    nsig_d      = nsig_q;
    nsymb_d     = nsymb_q;
    nloc_d      = nloc_q;
    start_ph_d  = start_ph_q;
    start_inc_d = start_inc_q;
    dph_inc_d   = dph_inc_q;
    nph_shift_d = nph_shift_q;
    chan_off_d  = chan_off_q;
    oneshot_d   = oneshot_q;
    n_d         = n_q;
    symb_d      = symb_q;
    loc_d       = loc_q;
    phase_d     = phase_q;
    inc_d       = inc_q;
    sph_d       = sph_q;
    sync_d      = sync_q;

    if (srst) begin
      state_d = S_IDLE;
      n_d     = NSIG_WIDTH'(1);
      symb_d  = NSYMB_WIDTH'(1);
      loc_d   = '0;
      phase_d = start_ph_q;
      inc_d   = start_inc_q;
      sph_d   = start_ph_q;
      sync_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_load) begin
            nsig_d      = cfg_nsig;
            nsymb_d     = cfg_nsymb;
            nloc_d      = cfg_nloc;
            start_ph_d  = cfg_start_ph;
            start_inc_d = cfg_start_inc;
            dph_inc_d   = cfg_dph_inc;
            nph_shift_d = cfg_nph_shift;
            chan_off_d  = cfg_chan_offset;
            oneshot_d   = cfg_oneshot;
            phase_d     = cfg_start_ph;
            inc_d       = cfg_start_inc;
            sph_d       = cfg_start_ph;
            sync_d      = 1'b0;
          end
          if (enable) state_d = S_RUN;
        end
        S_RUN: begin
          if (hs) begin
            if (!last_sample) begin
              phase_d = phase_q + inc_q;
              n_d     = n_q + NSIG_WIDTH'(1);
            end else begin
              n_d = NSIG_WIDTH'(1);
              if (!last_symb) begin
                phase_d = sph_q - nph_shift_q;
                sph_d   = sph_q - nph_shift_q;
                inc_d   = inc_q + $unsigned(dph_inc_q);
                symb_d  = symb_q + NSYMB_WIDTH'(1);
              end else begin
                symb_d  = NSYMB_WIDTH'(1);
                phase_d = start_ph_q;
                sph_d   = start_ph_q;
                inc_d   = start_inc_q;
                loc_d   = sat_inc_loc(loc_q, nloc_eff);
                if (loc_d == nloc_eff) begin
                  sync_d = 1'b1;
                  if (oneshot_q) state_d = S_DONE;
                end
              end
            end
            // A dropped enable only takes effect once the pending beat is accepted.
            if (state_d != S_DONE && !enable) state_d = S_IDLE;
          end
        end
        default: state_d = S_DONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      nsig_q      <= DEF_NSIG;
      nsymb_q     <= DEF_NSYMB;
      nloc_q      <= DEF_NLOC;
      start_ph_q  <= '0;
      start_inc_q <= DEF_START_INC;
      dph_inc_q   <= DEF_DPH_INC;
      nph_shift_q <= '0;
      chan_off_q  <= '0;
      oneshot_q   <= 1'b0;
      n_q         <= NSIG_WIDTH'(1);
      symb_q      <= NSYMB_WIDTH'(1);
      loc_q       <= '0;
      phase_q     <= '0;
      inc_q       <= DEF_START_INC;
      sph_q       <= '0;
      sync_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nsig_q      <= nsig_d;
      nsymb_q     <= nsymb_d;
      nloc_q      <= nloc_d;
      start_ph_q  <= start_ph_d;
      start_inc_q <= start_inc_d;
      dph_inc_q   <= dph_inc_d;
      nph_shift_q <= nph_shift_d;
      chan_off_q  <= chan_off_d;
      oneshot_q   <= oneshot_d;
      n_q         <= n_d;
      symb_q      <= symb_d;
      loc_q       <= loc_d;
      phase_q     <= phase_d;
      inc_q       <= inc_d;
      sph_q       <= sph_d;
      sync_q      <= sync_d;
    end
  end

endmodule

// File: tb/tb_tag_phase_sweep_gen.sv
// Directed/randomized bench for tag_phase_sweep_gen. Expected phases come from
// the closed form phase(s,n) = start_ph - s*nph_shift + n*(start_inc + s*dph_inc)
// with s,n the 0-based symbol and sample indices within a sweep.
module tb_tag_phase_sweep_gen;
  localparam int PW = 24;

  logic              clk = 1'b0;
  logic              reset, srst, cfg_load, enable, cfg_oneshot;
  logic [23:0]       cfg_nsig;
  logic [15:0]       cfg_nsymb;
  logic [7:0]        cfg_nloc;
  logic [PW-1:0]     cfg_start_ph, cfg_start_inc, cfg_nph_shift;
  logic signed [PW-1:0] cfg_dph_inc;
  logic [2*PW-1:0]   cfg_chan_offset;
  logic              sync_ready, done;
  logic [15:0]       symb_count;
  logic [7:0]        loc_count;

  tag_phase_sweep_gen_if #(.PHASE_WIDTH(PW), .NCHAN(2)) bus ();

  tag_phase_sweep_gen #(
    .PHASE_WIDTH(PW), .NSIG_WIDTH(24), .NSYMB_WIDTH(16), .NLOC_WIDTH(8), .NCHAN(2)
  ) dut (
    .clk(clk), .reset(reset), .srst(srst), .cfg_load(cfg_load),
    .cfg_nsig(cfg_nsig), .cfg_nsymb(cfg_nsymb), .cfg_nloc(cfg_nloc),
    .cfg_start_ph(cfg_start_ph), .cfg_start_inc(cfg_start_inc),
    .cfg_dph_inc(cfg_dph_inc), .cfg_nph_shift(cfg_nph_shift),
    .cfg_chan_offset(cfg_chan_offset), .cfg_oneshot(cfg_oneshot),
    .enable(enable), .m(bus), .sync_ready(sync_ready), .done(done),
    .symb_count(symb_count), .loc_count(loc_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int k_exp    = 0;

  // Reference model configuration
  longint mc_nsig, mc_nsymb, mc_nloc, mc_sph, mc_inc, mc_dph, mc_nsh, mc_off0, mc_off1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] exp_lane(input int k, input longint off);
    longint per, idx, s, n, v;
    per = mc_nsig * mc_nsymb;
    idx = longint'(k) % per;
    s   = idx / mc_nsig;
    n   = idx % mc_nsig;
    v   = mc_sph - s * mc_nsh + n * (mc_inc + s * mc_dph) + off;
    return v[PW-1:0];
  endfunction

  task automatic check_beat(input int k);
    longint per, idx, s, n, loc;
    per = mc_nsig * mc_nsymb;
    idx = longint'(k) % per;
    s   = idx / mc_nsig;
    n   = idx % mc_nsig;
    loc = longint'(k) / per;
    if (loc > mc_nloc) loc = mc_nloc;
    chk("lane0", 64'(bus.m_tdata[PW-1:0]), 64'(exp_lane(k, mc_off0)));
    chk("lane1", 64'(bus.m_tdata[2*PW-1:PW]), 64'(exp_lane(k, mc_off1)));
    chk("tlast", 64'(bus.m_tlast), 64'(n == mc_nsig - 1));
    chk("eos", 64'(bus.m_eos), 64'((n == mc_nsig - 1) && (s == mc_nsymb - 1)));
    chk("symb_count", 64'(symb_count), 64'(s + 1));
    chk("loc_count", 64'(loc_count), 64'(loc));
  endtask

  // Accept nbeats beats with m_tready high rdy_pct percent of the time;
  // a stalled beat must be presented unchanged on the following cycle.
  task automatic collect(input int nbeats, input int rdy_pct);
    int got, cyc;
    logic stalled;
    logic [2*PW-1:0] held;
    got = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (got < nbeats && cyc < 2000) begin
      bus.m_tready = ($urandom_range(0, 99) < rdy_pct);
      if (stalled) begin
        chk("stall_valid", 64'(bus.m_tvalid), 64'd1);
        chk("stall_data", 64'(bus.m_tdata), 64'(held));
      end
      stalled = 1'b0;
      if (bus.m_tvalid) begin
        if (bus.m_tready) begin
          check_beat(k_exp);
          k_exp++;
          got++;
        end else begin
          stalled = 1'b1;
          held = bus.m_tdata;
        end
      end
      tick();
      cyc++;
    end
    chk("beat_count", 64'(got), 64'(nbeats));
  endtask

  task automatic set_small_cfg(input logic oneshot);
    cfg_nsig = 24'd4; cfg_nsymb = 16'd2; cfg_nloc = 8'd2;
    cfg_start_ph = '0; cfg_start_inc = 24'd16; cfg_dph_inc = 24'sd8;
    cfg_nph_shift = 24'd3; cfg_chan_offset = {24'h800000, 24'h000000};
    cfg_oneshot = oneshot;
  endtask

  task automatic load_cfg();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    mc_nsig = cfg_nsig; mc_nsymb = cfg_nsymb; mc_nloc = cfg_nloc;
    mc_sph = cfg_start_ph; mc_inc = cfg_start_inc; mc_dph = longint'(cfg_dph_inc);
    mc_nsh = cfg_nph_shift;
    mc_off0 = cfg_chan_offset[PW-1:0]; mc_off1 = cfg_chan_offset[2*PW-1:PW];
  endtask

  task automatic pulse_srst();
    srst = 1'b1;
    tick();
    srst = 1'b0;
  endtask

  initial begin
    reset = 1'b1; srst = 1'b0; cfg_load = 1'b0; enable = 1'b0; bus.m_tready = 1'b0;
    set_small_cfg(1'b1);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("rst_tlast", 64'(bus.m_tlast), 64'd0);
    chk("rst_eos", 64'(bus.m_eos), 64'd0);
    chk("rst_sync", 64'(sync_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_symb", 64'(symb_count), 64'd1);
    chk("rst_loc", 64'(loc_count), 64'd0);

    // Default configuration: ramp 0, 4194304, 8388608 ...
    mc_nsig = 262144; mc_nsymb = 64; mc_nloc = 7; mc_sph = 0; mc_inc = 4194304;
    mc_dph = -131072; mc_nsh = 0; mc_off0 = 0; mc_off1 = 0;
    k_exp = 0;
    enable = 1'b1;
    collect(4, 100);
    enable = 1'b0;
    tick();
    chk("def_stop_tvalid", 64'(bus.m_tvalid), 64'd0);

    // One-shot small config with lane-1 offset of half a turn
    reset = 1'b1; tick(); reset = 1'b0;
    set_small_cfg(1'b1);
    load_cfg();
    chk("load_sync", 64'(sync_ready), 64'd0);
    k_exp = 0;
    enable = 1'b1;
    collect(16, 100);
    chk("os_sync", 64'(sync_ready), 64'd1);
    chk("os_done", 64'(done), 64'd1);
    chk("os_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("os_loc", 64'(loc_count), 64'd2);
    tick();
    chk("os_done_hold", 64'(done), 64'd1);
    chk("os_tvalid_hold", 64'(bus.m_tvalid), 64'd0);

    // srst out of DONE, then random start phase/offsets with random back-pressure
    enable = 1'b0;
    pulse_srst();
    chk("srst_done", 64'(done), 64'd0);
    chk("srst_sync", 64'(sync_ready), 64'd0);
    chk("srst_symb", 64'(symb_count), 64'd1);
    chk("srst_loc", 64'(loc_count), 64'd0);
    cfg_start_ph = PW'($urandom);
    cfg_chan_offset = {PW'($urandom), PW'($urandom)};
    load_cfg();
    k_exp = 0;
    enable = 1'b1;
    collect(16, 50);
    chk("rnd_done", 64'(done), 64'd1);
    chk("rnd_sync", 64'(sync_ready), 64'd1);

    // Continuous mode; enable dropped while the downstream stalls
    enable = 1'b0;
    pulse_srst();
    set_small_cfg(1'b0);
    load_cfg();
    k_exp = 0;
    enable = 1'b1;
    collect(2, 100);
    enable = 1'b0;
    bus.m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_tvalid", 64'(bus.m_tvalid), 64'd1);
      chk("hold_lane0", 64'(bus.m_tdata[PW-1:0]), 64'(exp_lane(k_exp, mc_off0)));
      tick();
    end
    bus.m_tready = 1'b1;
    tick();
    k_exp++;
    chk("drop_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("drop_symb", 64'(symb_count), 64'd1);
    tick();
    chk("idle_tvalid", 64'(bus.m_tvalid), 64'd0);
    enable = 1'b1;
    collect(3, 100);

    // cfg_load during RUN is ignored; srst at symbol 2 restarts with config kept
    cfg_nsig = 24'd7; cfg_start_inc = 24'd999; cfg_load = 1'b1;
    collect(1, 100);
    cfg_load = 1'b0;
    set_small_cfg(1'b0);
    chk("run_symb2", 64'(symb_count), 64'd2);
    pulse_srst();
    chk("srst_run_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("srst_run_symb", 64'(symb_count), 64'd1);
    k_exp = 0;
    collect(8, 100);

    enable = 1'b0;
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
